// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM autoload/host-read/bit-bang arbiter.
package eeprom_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 8;

    localparam logic [WORD_W-1:0] CSUM_GOOD_DEF = 16'hBABA;

    typedef enum logic [2:0] {
        LOAD_REQ  = 3'd0,
        LOAD_WAIT = 3'd1,
        IDLE      = 3'd2,
        RD_REQ    = 3'd3,
        RD_WAIT   = 3'd4,
        BB_GNT    = 3'd5
    } state_e;

endpackage

// File: rtl/eeprom_csum.sv
// 16-bit wrap-around checksum accumulator used during autoload.
// match_o_c reports whether the sum including the word being added equals CSUM_GOOD.
module eeprom_csum
    import eeprom_pkg::*;
#(
    parameter logic [WORD_W-1:0] CSUM_GOOD = CSUM_GOOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              match_o_c
);

    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] sum_d;
    logic [WORD_W-1:0] sum_next;

    assign sum_next  = WORD_W'(sum_q + data_i);
    assign match_o_c = (sum_next == CSUM_GOOD);

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/eeprom_arbiter.sv
// Sequencer/arbiter for the shared EEPROM read engine and pins: autoload, host EERD reads, EECD bit-bang grant.
// Autoload and checksum are present only when EEPROM_AUTOLOAD_EN is defined.
module eeprom_arbiter
    import eeprom_pkg::*;
#(
    parameter int unsigned       LOAD_WORDS = 64,
    parameter logic [WORD_W-1:0] CSUM_GOOD  = CSUM_GOOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eerd_start,
    input  logic [ADDR_W-1:0] eerd_addr,
    output logic [WORD_W-1:0] eerd_data,
    output logic              eerd_done,
    input  logic              ee_req,
    output logic              ee_gnt,
    output logic              bb_sel,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_addr,
    input  logic              eng_busy,
    input  logic              eng_valid,
    input  logic [WORD_W-1:0] eng_data,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [WORD_W-1:0] ld_data,
    output logic              load_done,
    output logic              csum_ok
);

    if (LOAD_WORDS < 1 || LOAD_WORDS > 256 || $bits(CSUM_GOOD) != WORD_W) begin : g_bad_cfg
        $error("eeprom_arbiter: LOAD_WORDS must be 1..256");
    end

`ifdef EEPROM_AUTOLOAD_EN
    localparam state_e RST_STATE = LOAD_REQ;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              csum_clr, csum_add, csum_match;

    eeprom_csum #(.CSUM_GOOD(CSUM_GOOD)) u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (csum_clr),
        .add_i    (csum_add),
        .data_i   (eng_data),
        .match_o_c(csum_match)
    );
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [WORD_W-1:0] eerd_data_q, eerd_data_d;
    logic              eerd_done_q, eerd_done_d;
    logic              ee_gnt_q, ee_gnt_d;
    logic              bb_sel_q, bb_sel_d;
    logic              eng_start_q, eng_start_d;
    logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic              ld_we_q, ld_we_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [WORD_W-1:0] ld_data_q, ld_data_d;
    logic              load_done_q, load_done_d;
    logic              csum_ok_q, csum_ok_d;

    // A start arriving this cycle is visible immediately so IDLE can issue without a bubble.
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    assign rd_pend = pend_q | eerd_start;
    assign rd_addr = eerd_start ? eerd_addr : pend_addr_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        eerd_data_d = eerd_data_q;
        eerd_done_d = eerd_done_q;
        ee_gnt_d    = ee_gnt_q;
        bb_sel_d    = bb_sel_q;
        eng_start_d = 1'b0;
        eng_addr_d  = eng_addr_q;
        ld_we_d     = 1'b0;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        load_done_d = load_done_q;
        csum_ok_d   = csum_ok_q;
`ifdef EEPROM_AUTOLOAD_EN
        idx_d       = idx_q;
        csum_clr    = 1'b0;
        csum_add    = 1'b0;
`else
        load_done_d = 1'b1;
`endif

        case (state_q)
`ifdef EEPROM_AUTOLOAD_EN
            LOAD_REQ: begin
                csum_clr = (idx_q == '0);
                if (!eng_busy) begin
                    eng_start_d = 1'b1;
                    eng_addr_d  = idx_q;
                    state_d     = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (eng_valid) begin
                    ld_we_d   = 1'b1;
                    ld_addr_d = idx_q;
                    ld_data_d = eng_data;
                    csum_add  = 1'b1;
                    if (idx_q == ADDR_W'(LOAD_WORDS - 1)) begin
                        load_done_d = 1'b1;
                        csum_ok_d   = csum_match;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = LOAD_REQ;
                    end
                end
            end
`endif
            IDLE: begin
                if (rd_pend) begin
                    if (!eng_busy) begin
                        eng_start_d = 1'b1;
                        eng_addr_d  = rd_addr;
                        state_d     = RD_WAIT;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (ee_req && !eng_busy) begin
                    ee_gnt_d = 1'b1;
                    bb_sel_d = 1'b1;
                    state_d  = BB_GNT;
                end
            end
            RD_REQ: begin
                if (!eng_busy) begin
                    eng_start_d = 1'b1;
                    eng_addr_d  = rd_addr;
                    state_d     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (eng_valid) begin
                    eerd_data_d = eng_data;
                    eerd_done_d = 1'b1;
                    pend_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            BB_GNT: begin
                if (!ee_req) begin
                    ee_gnt_d = 1'b0;
                    bb_sel_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new host start always wins over completion in the same cycle.
        if (eerd_start) begin
            pend_d      = 1'b1;
            pend_addr_d = eerd_addr;
            eerd_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            eerd_data_q <= '0;
            eerd_done_q <= 1'b0;
            ee_gnt_q    <= 1'b0;
            bb_sel_q    <= 1'b0;
            eng_start_q <= 1'b0;
            eng_addr_q  <= '0;
            ld_we_q     <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            load_done_q <= 1'b0;
            csum_ok_q   <= 1'b0;
`ifdef EEPROM_AUTOLOAD_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            eerd_data_q <= eerd_data_d;
            eerd_done_q <= eerd_done_d;
            ee_gnt_q    <= ee_gnt_d;
            bb_sel_q    <= bb_sel_d;
            eng_start_q <= eng_start_d;
            eng_addr_q  <= eng_addr_d;
            ld_we_q     <= ld_we_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            load_done_q <= load_done_d;
            csum_ok_q   <= csum_ok_d;
`ifdef EEPROM_AUTOLOAD_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign eerd_data = eerd_data_q;
    assign eerd_done = eerd_done_q;
    assign ee_gnt    = ee_gnt_q;
    assign bb_sel    = bb_sel_q;
    assign eng_start = eng_start_q;
    assign eng_addr  = eng_addr_q;
    assign ld_we     = ld_we_q;
    assign ld_addr   = ld_addr_q;
    assign ld_data   = ld_data_q;
    assign load_done = load_done_q;
    assign csum_ok   = csum_ok_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Bench for eeprom_arbiter: engine responder backed by a word array, directed scenarios plus random host reads.
// Autoload checks are compiled in only when EEPROM_AUTOLOAD_EN is defined.
module tb_eeprom_arbiter;

    localparam int unsigned NLOAD    = 4;
    localparam logic [15:0] CSUM_REF = 16'hBABA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        eerd_start, ee_req, eng_busy, eng_valid;
    logic [7:0]  eerd_addr;
    logic [15:0] eng_data;
    logic [15:0] eerd_data, ld_data;
    logic        eerd_done, ee_gnt, bb_sel, eng_start, ld_we, load_done, csum_ok;
    logic [7:0]  eng_addr, ld_addr;

    int          nchk = 0;
    int          npass = 0;
    int          nstart = 0;
    int          lat = 2;
    logic [7:0]  last_start_addr = 8'd0;
    logic [15:0] mem [256];
    logic [7:0]  ld_a_q[$];
    logic [15:0] ld_d_q[$];

    always #5 clk = ~clk;

    eeprom_arbiter #(.LOAD_WORDS(NLOAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .eerd_start(eerd_start), .eerd_addr(eerd_addr), .eerd_data(eerd_data), .eerd_done(eerd_done),
        .ee_req(ee_req), .ee_gnt(ee_gnt), .bb_sel(bb_sel),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_data(eng_data),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .load_done(load_done), .csum_ok(csum_ok)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({eerd_data, eerd_done, ee_gnt, bb_sel, eng_start, eng_addr, ld_we,
                    ld_addr, ld_data, load_done, csum_ok});
    endfunction

    function automatic logic csum_model();
        logic [15:0] s = 16'h0;
        for (int i = 0; i < int'(NLOAD); i++) s = s + mem[i];
        return (s == CSUM_REF);
    endfunction

    task automatic wait_done(input string tag);
        for (int c = 0; c < 200 && !eerd_done; c++) @(negedge clk);
        chk({tag, "_done"}, 64'(eerd_done), 64'd1);
    endtask

    task automatic wait_load(input string tag);
        for (int c = 0; c < 400 && !load_done; c++) @(negedge clk);
        chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    endtask

    task automatic check_load(input string tag);
        chk({tag, "_ld_count"}, 64'(ld_a_q.size()), 64'(NLOAD));
        for (int i = 0; i < ld_a_q.size() && i < int'(NLOAD); i++) begin
            chk({tag, "_ld_addr"}, 64'(ld_a_q[i]), 64'(i));
            chk({tag, "_ld_data"}, 64'(ld_d_q[i]), 64'(mem[i]));
        end
        chk({tag, "_csum_ok"}, 64'(csum_ok), 64'(csum_model()));
    endtask

    task automatic host_read(input logic [7:0] a, input string tag, input bit check_start);
        eerd_start = 1'b1;
        eerd_addr  = a;
        @(negedge clk);
        eerd_start = 1'b0;
        chk({tag, "_done_cleared"}, 64'(eerd_done), 64'd0);
        if (check_start) chk({tag, "_start_next_cycle"}, 64'({eng_start, eng_addr}), 64'({1'b1, a}));
        wait_done(tag);
        chk({tag, "_data"}, 64'(eerd_data), 64'(mem[a]));
        chk({tag, "_eng_addr"}, 64'(last_start_addr), 64'(a));
    endtask

    // Engine responder and pin-use monitor, sampled just after each rising edge.
    initial begin : engine
        logic        busy_prev;
        logic        bb_prev;
        int          cnt;
        logic [15:0] cur;
        eng_busy = 1'b0; eng_valid = 1'b0; eng_data = 16'h0;
        bb_prev = 1'b0; cnt = 0; cur = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            busy_prev = eng_busy;
            eng_valid = 1'b0;
            if (ld_we) begin
                ld_a_q.push_back(ld_addr);
                ld_d_q.push_back(ld_data);
            end
            if (bb_sel !== bb_prev) chk("bb_sel_change_while_busy", 64'(busy_prev), 64'd0);
            bb_prev = bb_sel;
            if (eng_start) begin
                chk("eng_start_while_busy_or_bb", 64'({busy_prev, bb_sel}), 64'd0);
                nstart++;
                last_start_addr = eng_addr;
            end
            if (!rst_n) begin
                eng_busy = 1'b0;
                cnt = 0;
            end else if (eng_busy) begin
                if (cnt == 0) begin
                    eng_valid = 1'b1;
                    eng_data  = cur;
                    eng_busy  = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (eng_start) begin
                eng_busy = 1'b1;
                cnt = lat;
                cur = mem[eng_addr];
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, nchk);
        $fatal(1);
    end

    initial begin : main
        logic [7:0] a;
        int         snap;
        bit         found;
        ee_req = 1'b0; eerd_start = 1'b0; eerd_addr = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h5454;
        mem[5] = 16'hABCD;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;

`ifdef EEPROM_AUTOLOAD_EN
        wait_load("autoload");
        check_load("autoload");
`else
        @(negedge clk);
        chk("noload_load_done", 64'(load_done), 64'd1);
        chk("noload_csum_ok", 64'(csum_ok), 64'd0);
        repeat (8) @(negedge clk);
        chk("noload_no_start", 64'(nstart), 64'd0);
`endif

        // Host read from IDLE, then a second read that must clear eerd_done.
        @(negedge clk);
        host_read(8'h05, "read5", 1'b1);
        @(negedge clk);
        host_read(8'h21, "read21", 1'b1);

        // ee_req and eerd_start together: the read is served before the grant.
        @(negedge clk);
        mem[8'h40] = 16'h0F0F;
        ee_req = 1'b1; eerd_start = 1'b1; eerd_addr = 8'h40;
        @(negedge clk);
        eerd_start = 1'b0;
        chk("same_cycle_gnt_held", 64'(ee_gnt), 64'd0);
        wait_done("same_cycle");
        chk("same_cycle_data", 64'(eerd_data), 64'(mem[8'h40]));
        chk("same_cycle_gnt_after_done", 64'(ee_gnt), 64'd0);
        @(negedge clk);
        chk("same_cycle_grant", 64'({ee_gnt, bb_sel}), 64'b11);

        // Reads requested during the grant wait; the newer address replaces the older one.
        snap = nstart;
        eerd_start = 1'b1; eerd_addr = 8'h03;
        @(negedge clk);
        eerd_start = 1'b0;
        repeat (3) @(negedge clk);
        eerd_start = 1'b1; eerd_addr = 8'h07;
        @(negedge clk);
        eerd_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("bb_no_start", 64'(nstart), 64'(snap));
        chk("bb_done_cleared", 64'(eerd_done), 64'd0);
        chk("bb_still_granted", 64'({ee_gnt, bb_sel}), 64'b11);
        ee_req = 1'b0;
        @(negedge clk);
        chk("bb_release", 64'({ee_gnt, bb_sel, eng_start}), 64'b000);
        @(negedge clk);
        chk("bb_pending_start", 64'({eng_start, eng_addr}), 64'({1'b1, 8'h07}));
        wait_done("bb_pending");
        chk("bb_pending_data", 64'(eerd_data), 64'(mem[8'h07]));
        chk("bb_one_start", 64'(nstart), 64'(snap + 1));

        // Random reads with random engine latency and interleaved bit-bang episodes.
        for (int i = 0; i < 12; i++) begin
            lat = int'($urandom_range(0, 4));
            a = 8'($urandom);
            mem[a] = 16'($urandom);
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                ee_req = 1'b1;
                @(negedge clk);
                chk("rand_grant", 64'({ee_gnt, bb_sel}), 64'b11);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                ee_req = 1'b0;
                @(negedge clk);
                chk("rand_release", 64'({ee_gnt, bb_sel}), 64'b00);
            end
            host_read(a, "rand", 1'b1);
        end

`ifdef EEPROM_AUTOLOAD_EN
        // Reset in the middle of the third autoload word, then a full restart with a bad checksum.
        lat = 3;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ld_a_q.delete(); ld_d_q.delete();
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = eng_start && (eng_addr == 8'd2);
        end
        chk("midload_reached_idx2", 64'(found), 64'd1);
        chk("midload_writes_before", 64'(ld_a_q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midload_reset_outputs", outs(), 64'd0);
        ld_a_q.delete(); ld_d_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_load("reload");
        check_load("reload");
`else
        // Reset during a host read, then confirm no load activity afterwards.
        lat = 4;
        @(negedge clk);
        eerd_start = 1'b1; eerd_addr = 8'h11;
        @(negedge clk);
        eerd_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midread_reset_outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        snap = nstart;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midread_load_done", 64'({load_done, csum_ok}), 64'b10);
        repeat (6) @(negedge clk);
        chk("midread_no_start", 64'(nstart), 64'(snap));
        chk("noload_no_ld_we", 64'(ld_a_q.size()), 64'd0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
